// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory controller.
// Size decode is kept here so lane logic and FSM agree on byte counts.
package dmem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } dmem_size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } dmem_state_e;

    // Reserved size behaves as a full word.
    function automatic logic [3:0] size_to_mask(input dmem_size_e size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_to_nbytes(input dmem_size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] be_to_bits(input logic [3:0] be);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[i*8 +: 8] = {8{be[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: write mode shifts mask/data into SRAM lanes for either access half,
// read mode right-justifies a {hi,lo} pair and reports the valid lanes. Purely combinational.
module dmem_lane_align (
    input  logic        rd_mode,
    input  logic        half,
    input  logic [1:0]  off,
    input  logic [3:0]  mask,
    input  logic [63:0] data,
    output logic [3:0]  be,
    output logic [31:0] data_out
);

    logic [7:0] mask_wide;
    logic [4:0] sh_lo;
    logic [5:0] sh_hi;

    always_comb begin
        // Upper nibble of the widened mask is exactly the spill into the next word.
        mask_wide = {4'b0000, mask} << off;
        sh_lo     = {off, 3'b000};
        sh_hi     = 6'd32 - {1'b0, off, 3'b000};
        if (rd_mode) begin
            be       = mask;
            data_out = 32'(data >> sh_lo);
        end else if (half) begin
            be       = mask_wide[7:4];
            data_out = data[31:0] >> sh_hi;
        end else begin
            be       = mask_wide[3:0];
            data_out = data[31:0] << sh_lo;
        end
    end

endmodule

// File: rtl/data_memory_controller.sv
// Single-outstanding load/store controller for a word-wide SRAM; splits word-straddling accesses.
// Latency 2-4 cycles to rsp_valid; response held until rsp_ready, requests only taken in IDLE.
module data_memory_controller #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [3:0]            ram_be,
    output logic [XLEN-1:0]       ram_wdata,
    input  logic [XLEN-1:0]       ram_rdata
);

    import dmem_pkg::*;

    localparam int WAW = ADDR_WIDTH - 2;
    localparam logic [WAW-1:0] WORD_ONE = WAW'(1);

    dmem_state_e state, state_nxt;

    logic                  wr_q;
    dmem_size_e            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [XLEN-1:0]       lo_word;
    logic [XLEN-1:0]       hi_word;

    logic [1:0]     off;
    logic [3:0]     mask;
    logic [2:0]     nbytes;
    logic           split;
    logic [WAW-1:0] word0;
    logic           in_acc1;
    logic [3:0]     wr_be;
    logic [31:0]    wr_dat;
    logic [3:0]     rd_be;
    logic [31:0]    rd_dat;

    assign off     = addr_q[1:0];
    assign mask    = size_to_mask(size_q);
    assign nbytes  = size_to_nbytes(size_q);
    assign split   = ({1'b0, off} + nbytes) > 3'd4;
    assign word0   = addr_q[ADDR_WIDTH-1:2];
    assign in_acc1 = (state == ACC1);

    dmem_lane_align u_wr_lanes (
        .rd_mode  (1'b0),
        .half     (in_acc1),
        .off      (off),
        .mask     (mask),
        .data     ({{XLEN{1'b0}}, wdata_q}),
        .be       (wr_be),
        .data_out (wr_dat)
    );

    dmem_lane_align u_rd_lanes (
        .rd_mode  (1'b1),
        .half     (1'b0),
        .off      (off),
        .mask     (mask),
        .data     ({hi_word, lo_word}),
        .be       (rd_be),
        .data_out (rd_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = ACC0;
            ACC0: begin
                if (split)      state_nxt = ACC1;
                else if (wr_q)  state_nxt = RESP;
                else            state_nxt = CAPT;
            end
            ACC1: state_nxt = wr_q ? RESP : CAPT;
            CAPT: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_rdata = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_be    = '0;
        ram_wdata = '0;
        if (state == ACC0 || state == ACC1) begin
            ram_en    = 1'b1;
            ram_we    = wr_q;
            ram_addr  = in_acc1 ? word0 + WORD_ONE : word0;
            ram_be    = wr_be;
            ram_wdata = wr_dat;
        end
        if (state == RESP && !wr_q) begin
            rsp_rdata = rd_dat & be_to_bits(rd_be);
        end
    end

    // SRAM read data lags the strobe by one cycle, so each capture trails its access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_word <= '0;
            hi_word <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                wr_q    <= req_write;
                size_q  <= dmem_size_e'(req_size);
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == ACC1 && !wr_q) begin
                lo_word <= ram_rdata;
            end
            if (state == CAPT) begin
                if (split) hi_word <= ram_rdata;
                else       lo_word <= ram_rdata;
            end
        end
    end

endmodule
